mdu_unit: RTL
=============

Name: mdu_unit

Overview:
- Execute-stage multiply/divide unit with HI/LO register file.
- Consumes the 4-bit alu_class field produced by the decode controller:
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo.
- Models fixed multi-cycle latency with a busy counter and exposes start/busy for the hazard unit's stall logic.
- Returns HI/LO for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu.
- DIV_CYCLES, 10, busy duration in cycles for div/divu.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- issue  input  1  E-stage instruction valid and advancing this cycle
- alu_class  input  4  operation class from controller, encoding above
- src_a  input  32  forwarded rs value
- src_b  input  32  forwarded rt value
- start  output  1  combinational: issue & alu_class in 1..4 & ~busy
- busy  output  1  registered: unit computing
- hi  output  32  current HI register
- lo  output  32  current LO register
- md_rdata  output  32  combinational read data: hi if class 5, lo if class 6, else 0

Behaviour:
- Reset (reset_n=0, asynchronous):
  - busy=0, hi=0, lo=0, counter=0, pending results=0, FSM to IDLE.
  - Reset mid-operation discards the pending result.
- FSM states IDLE and BUSY.
- IDLE, issue & class 1..4 (start=1):
  - At the edge, latch the computed result into pend_hi/pend_lo.
  - Load counter with MULT_CYCLES (class 1,2) or DIV_CYCLES (class 3,4).
  - Go to BUSY; busy=1 from the next cycle.
- BUSY:
  - Counter decrements each edge.
  - On the edge where counter goes 1->0: hi<=pend_hi, lo<=pend_lo, busy<=0, go to IDLE.
  - busy is therefore high for exactly N cycles after the start edge.
  - New values are visible on hi/lo in the same cycle busy is first low.
- mult: {hi,lo} = signed src_a * signed src_b (64-bit). multu: unsigned product.
- div: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - Special case -2^31 / -1: lo=0x80000000, hi=0.
- divu: unsigned quotient and remainder.
- Divide by zero (src_b=0): unit still goes busy for DIV_CYCLES; hi/lo unchanged at completion.
- mthi / mtlo (class 7/8) with issue in IDLE: hi<=src_a (or lo<=src_a) at the edge, no busy.
- Any issue of class 1..4, 7 or 8 while busy=1 is ignored; state and hi/lo unchanged.
  - The hazard unit guarantees this never happens; the bench asserts it.
- mfhi/mflo are combinational reads of the current hi/lo and are not gated by busy (the hazard unit stalls these).
- issue=0: no state change regardless of alu_class.
- class 0 and 9..15: no effect; md_rdata=0.

Decomposition:
- Shared package mdu_pkg:
  - class constants MD_NONE..MD_MTLO (4-bit), MD_MULT_CYCLES=5, MD_DIV_CYCLES=10.
  - These are also used by the controller and the hazard unit.
- One combinational sub-module mdu_calc(class, a, b -> res_hi, res_lo, div_zero):
  - holds all signed/unsigned arithmetic, including the overflow and divide-by-zero cases.
  - mdu_unit keeps only the FSM, counter and registers.

Test Plan:
- Reset then idle: reset_n low mid-cycle -> busy=0, hi=lo=0 immediately (asynchronous). Then mfhi -> md_rdata=0.
- mult 0xFFFFFFFE * 0x00000003:
  - start=1 on issue cycle; busy=1 for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div -7 / 2:
  - busy for 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - divu 7/2 -> lo=3, hi=1.
  - div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero:
  - mthi 0x1234, mtlo 0x5678, then divu 9/0.
  - busy 10 cycles; afterwards hi=0x1234, lo=0x5678.
- Busy interference:
  - mult issued, then on busy cycle 2 issue mtlo 0xAAAA and a second mult -> both ignored.
  - Final hi/lo equal the first mult's result; busy falls at cycle 5.
- Reset mid-operation:
  - div issued; reset_n pulsed low on busy cycle 4 -> busy=0, hi=lo=0.
  - No later update after reset release.
  - A new mult then completes normally after 5 cycles.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the alu_class encoding driven by the decode controller, the default
// multi-cycle latencies, the unit's FSM state type and small class decoders.
// The class constants and latencies are also consumed by the controller and
// the hazard unit, so they must stay in sync with those blocks.
package mdu_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } mdu_state_e;

  // Classes that occupy the unit for multiple cycles.
  function automatic logic is_md_op(input logic [3:0] cls);
    return (cls >= MD_MULT) && (cls <= MD_DIVU);
  endfunction

  function automatic logic is_mult_op(input logic [3:0] cls);
    return (cls == MD_MULT) || (cls == MD_MULTU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational arithmetic core of the multiply/divide unit.
// Ports:
//   alu_class  in  4   operation class (mult/multu/div/divu produce results)
//   a, b       in  32  operands (a = rs / dividend, b = rt / divisor)
//   res_hi     out 32  HI result (product high word or remainder)
//   res_lo     out 32  LO result (product low word or quotient)
//   div_zero   out 1   div/divu with b == 0; caller must not commit results
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  alu_class,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        abs_a;
  logic [31:0]        abs_b;
  logic [31:0]        divisor_u;
  logic [31:0]        divisor_s;
  logic [31:0]        q_u;
  logic [31:0]        r_u;
  logic [31:0]        q_mag;
  logic [31:0]        r_mag;
  logic [31:0]        q_s;
  logic [31:0]        r_s;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide runs on magnitudes and fixes signs afterwards. This also
  // covers -2^31 / -1: the magnitude quotient 0x80000000 is left un-negated.
  assign abs_a = a[31] ? (~a + 32'd1) : a;
  assign abs_b = b[31] ? (~b + 32'd1) : b;

  // Substitute 1 for a zero divisor so the datapath never evaluates x/0;
  // results are discarded in that case anyway.
  assign divisor_u = (b == 32'd0) ? 32'd1 : b;
  assign divisor_s = (b == 32'd0) ? 32'd1 : abs_b;

  assign q_u   = a / divisor_u;
  assign r_u   = a % divisor_u;
  assign q_mag = abs_a / divisor_s;
  assign r_mag = abs_a % divisor_s;

  // Quotient truncates toward zero; remainder takes the dividend's sign.
  assign q_s = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s = a[31] ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    div_zero = 1'b0;
    case (alu_class)
      MD_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MD_DIV: begin
        res_hi   = r_s;
        res_lo   = q_s;
        div_zero = (b == 32'd0);
      end
      MD_DIVU: begin
        res_hi   = r_u;
        res_lo   = q_u;
        div_zero = (b == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// Execute-stage multiply/divide unit with HI/LO registers.
// Results are computed combinationally at issue and held in pending
// registers; a down-counter models the fixed latency, and HI/LO are written
// on the edge where the counter reaches zero.
// Ports:
//   clk        in  1   rising-edge clock
//   reset_n    in  1   asynchronous active-low reset
//   issue      in  1   E-stage instruction valid and advancing
//   alu_class  in  4   operation class from the controller
//   src_a      in  32  forwarded rs value
//   src_b      in  32  forwarded rt value
//   start      out 1   multi-cycle op accepted this cycle (combinational)
//   busy       out 1   unit computing (registered)
//   hi, lo     out 32  current HI / LO registers
//   md_rdata   out 32  mfhi/mflo read data, 0 for other classes
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        issue,
  input  logic [3:0]  alu_class,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rdata
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  mdu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic [31:0]     pend_hi_q, pend_hi_d;
  logic [31:0]     pend_lo_q, pend_lo_d;
  logic            pend_zero_q, pend_zero_d;

  logic [31:0]     res_hi;
  logic [31:0]     res_lo;
  logic            div_zero;

  mdu_calc u_calc (
    .alu_class (alu_class),
    .a         (src_a),
    .b         (src_b),
    .res_hi    (res_hi),
    .res_lo    (res_lo),
    .div_zero  (div_zero)
  );

  assign busy  = (state_q == StBusy);
  assign start = issue & is_md_op(alu_class) & ~busy;
  assign hi    = hi_q;
  assign lo    = lo_q;

  // Reads are not gated by busy; the hazard unit stalls mfhi/mflo instead.
  always_comb begin
    md_rdata = 32'd0;
    if (alu_class == MD_MFHI) begin
      md_rdata = hi_q;
    end else if (alu_class == MD_MFLO) begin
      md_rdata = lo_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    pend_zero_d = pend_zero_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          pend_hi_d   = res_hi;
          pend_lo_d   = res_lo;
          pend_zero_d = div_zero;
          cnt_d       = is_mult_op(alu_class) ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
          state_d     = StBusy;
        end else if (issue && (alu_class == MD_MTHI)) begin
          hi_d = src_a;
        end else if (issue && (alu_class == MD_MTLO)) begin
          lo_d = src_a;
        end
      end
      StBusy: begin
        // Any issue while busy is ignored.
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          if (!pend_zero_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      pend_hi_q   <= 32'd0;
      pend_lo_q   <= 32'd0;
      pend_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      pend_zero_q <= pend_zero_d;
    end
  end

endmodule
